// File: rtl/twofish_stream_ctrl.sv
// Streaming valid/ready wrapper around a fixed-latency pipelined Twofish core.
// Tracks tags alongside the core pipeline, buffers results in a credit-guarded FIFO and sequences key changes.
module twofish_stream_ctrl #(
   parameter int PIPE_DEPTH = 16,
   parameter int FIFO_DEPTH = 32,
   parameter int TAG_W      = 4,
   parameter int DATA_W     = 128,
   parameter int KEY_W      = 128
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [TAG_W-1:0]  in_tag_i,
   input  logic              key_load_i,
   input  logic [KEY_W-1:0]  key_in_i,
   output logic              key_busy_o,
   output logic [DATA_W-1:0] core_pt_o,
   output logic [KEY_W-1:0]  core_key_o,
   input  logic [DATA_W-1:0] core_ct_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [TAG_W-1:0]  out_tag_o,
   output logic [31:0]       blk_count_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CREDITS = CW'(FIFO_DEPTH);
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   logic [1:0]              state_q, state_d;
   logic                    pending_q, pending_d;
   logic [KEY_W-1:0]        pend_key_q, pend_key_d;
   logic [KEY_W-1:0]        core_key_q, core_key_d;
   logic [DATA_W-1:0]       core_pt_q, core_pt_d;
   logic [PIPE_DEPTH:0]     vpipe_q, vpipe_d;
   logic [TAG_W-1:0]        tpipe_q [PIPE_DEPTH+1];
   logic [CW-1:0]           credits_q, credits_d;
   logic [CW-1:0]           count_q, count_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [31:0]             blk_q, blk_d;
   logic [DATA_W+TAG_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W+TAG_W-1:0] head_s;
   logic                    accept_s, pop_s, wr_s;

   // Ready depends only on registered state, so a same-cycle key_load cannot block the current beat.
   assign in_ready_o  = !reset_i && (state_q == ST_RUN) && (credits_q != {CW{1'b0}}) && !pending_q;
   assign accept_s    = in_valid_i && in_ready_o;
   assign out_valid_o = (count_q != {CW{1'b0}});
   assign pop_s       = out_valid_o && out_ready_i;
   assign wr_s        = vpipe_q[PIPE_DEPTH];
   assign key_busy_o  = pending_q;
   assign core_pt_o   = core_pt_q;
   assign core_key_o  = core_key_q;
   assign blk_count_o = blk_q;

   // Key-change sequencing: a key is only installed once the core pipeline is empty.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      pend_key_d = pend_key_q;
      core_key_d = core_key_q;
      if (key_load_i) begin
         pending_d  = 1'b1;
         pend_key_d = key_in_i;
      end else begin
         pend_key_d = pend_key_q;
      end
      case (state_q)
         ST_RUN: begin
            if (key_load_i) state_d = ST_DRAIN;
            else            state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (vpipe_q == {(PIPE_DEPTH+1){1'b0}}) state_d = ST_LOAD;
            else                                   state_d = ST_DRAIN;
         end
         ST_LOAD: begin
            core_key_d = pend_key_q;
            if (key_load_i) begin
               state_d = ST_DRAIN;
            end else begin
               state_d   = ST_RUN;
               pending_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Input acceptance, credit accounting and FIFO pointer updates.
   always_comb begin
      vpipe_d = {vpipe_q[PIPE_DEPTH-1:0], accept_s};
      if (accept_s) begin
         core_pt_d = in_data_i;
         blk_d     = blk_q + 32'd1;
      end else begin
         core_pt_d = core_pt_q;
         blk_d     = blk_q;
      end
      case ({accept_s, pop_s})
         2'b10:   credits_d = credits_q - CW'(1'b1);
         2'b01:   credits_d = credits_q + CW'(1'b1);
         default: credits_d = credits_q;
      endcase
      case ({wr_s, pop_s})
         2'b10:   count_d = count_q + CW'(1'b1);
         2'b01:   count_d = count_q - CW'(1'b1);
         default: count_d = count_q;
      endcase
      if (wr_s) wr_ptr_d = wr_ptr_q + AW'(1'b1);
      else      wr_ptr_d = wr_ptr_q;
      if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1'b1);
      else       rd_ptr_d = rd_ptr_q;
   end

   // First-word fall-through head, forced to zero while the FIFO is empty.
   always_comb begin
      head_s = mem_q[rd_ptr_q];
      if (out_valid_o) begin
         out_data_o = head_s[DATA_W+TAG_W-1:TAG_W];
         out_tag_o  = head_s[TAG_W-1:0];
      end else begin
         out_data_o = {DATA_W{1'b0}};
         out_tag_o  = {TAG_W{1'b0}};
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_RUN;
         pending_q  <= 1'b0;
         pend_key_q <= {KEY_W{1'b0}};
         core_key_q <= {KEY_W{1'b0}};
         core_pt_q  <= {DATA_W{1'b0}};
         vpipe_q    <= {(PIPE_DEPTH+1){1'b0}};
         credits_q  <= FULL_CREDITS;
         count_q    <= {CW{1'b0}};
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         blk_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         pend_key_q <= pend_key_d;
         core_key_q <= core_key_d;
         core_pt_q  <= core_pt_d;
         vpipe_q    <= vpipe_d;
         credits_q  <= credits_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         blk_q      <= blk_d;
      end
   end

   // Tag shift register; stage PIPE_DEPTH lines up with core_ct_i.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i <= PIPE_DEPTH; i++) tpipe_q[i] <= {TAG_W{1'b0}};
      end else begin
         tpipe_q[0] <= in_tag_i;
         for (int i = 1; i <= PIPE_DEPTH; i++) tpipe_q[i] <= tpipe_q[i-1];
      end
   end

   // FIFO storage; credits guarantee a free slot whenever wr_s is set.
   always_ff @(posedge clk_i) begin
      if (wr_s) mem_q[wr_ptr_q] <= {core_ct_i, tpipe_q[PIPE_DEPTH]};
   end
endmodule
